// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory port: arbiter FSM states, access owner
// encoding and default bus widths.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of back-to-back DM grants taken while IF was waiting;
// at_max tells the arbiter to hand the next contested slot to IF.
module arb_streak_ctr #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int CW = $clog2(MAX_DSTREAK + 1);

    logic [CW-1:0] streak;

    assign at_max = (streak == CW'(MAX_DSTREAK));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (clr) begin
            streak <= '0;
        end else if (inc && !at_max) begin
            streak <= streak + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and DM accesses onto one fixed-latency synchronous memory port,
// one access in flight, DM preferred with a bounded streak so IF cannot starve.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LAT     = 1,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    state_t            state, state_nxt;
    owner_t            owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              idle;
    logic              at_max;
    logic              last_wait;
    logic [DATA_W-1:0] rd_val;

    // Grants are combinational and masked while reset is held so every output reads 0.
    assign idle      = (state == IDLE) && !reset;
    assign dm_gnt    = idle && dm_req && !(if_req && at_max);
    assign if_gnt    = idle && if_req && !dm_gnt;
    assign last_wait = (state == WAIT) && (cnt == CNT_W'(1));
    assign rd_val    = we_q ? '0 : mem_rdata;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    arb_streak_ctr #(
        .MAX_DSTREAK(MAX_DSTREAK)
    ) u_streak (
        .clk   (clk),
        .reset (reset),
        .inc   (dm_gnt && if_req),
        .clr   (if_gnt || (dm_gnt && !if_req)),
        .at_max(at_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_gnt || dm_gnt) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (last_wait) state_nxt = RESP;
            end
            RESP: begin
                if_rvalid = (owner == OWN_IF);
                dm_rvalid = (owner == OWN_DM);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch at grant, latency countdown, and response capture on the last WAIT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner    <= OWN_IF;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if (dm_gnt) begin
                owner   <= OWN_DM;
                we_q    <= dm_we;
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
            end else if (if_gnt) begin
                owner  <= OWN_IF;
                we_q   <= 1'b0;
                addr_q <= if_addr;
            end
            if (state == ISSUE) begin
                cnt <= CNT_W'(MEM_LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (last_wait) begin
                if (owner == OWN_DM) dm_rdata <= rd_val;
                else                 if_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance share stimulus,
// each checked every cycle against a transaction-timeline model plus directed checks.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;

    logic        if_gnt_w[2], if_rvalid_w[2], dm_gnt_w[2], dm_rvalid_w[2];
    logic        mem_en_w[2], mem_we_w[2];
    logic [31:0] if_rdata_w[2], dm_rdata_w[2], mem_addr_w[2], mem_wdata_w[2], mem_rdata_w[2];

    mem_port_arbiter #(.MEM_LAT(1), .MAX_DSTREAK(MAXS)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[0]),
        .if_rvalid(if_rvalid_w[0]), .if_rdata(if_rdata_w[0]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_w[0]), .dm_rvalid(dm_rvalid_w[0]), .dm_rdata(dm_rdata_w[0]),
        .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
        .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0])
    );

    mem_port_arbiter #(.MEM_LAT(3), .MAX_DSTREAK(MAXS)) u_lat3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[1]),
        .if_rvalid(if_rvalid_w[1]), .if_rdata(if_rdata_w[1]),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_w[1]), .dm_rvalid(dm_rvalid_w[1]), .dm_rdata(dm_rdata_w[1]),
        .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
        .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1])
    );

    // Memory models: read data appears MEM_LAT cycles after the mem_en cycle, junk otherwise.
    logic [31:0] hw_mem0[256];
    logic [31:0] hw_mem1[256];
    logic [31:0] rp0;
    logic [31:0] rp1[3];

    always @(posedge clk) begin
        if (mem_en_w[0] && mem_we_w[0]) hw_mem0[mem_addr_w[0][7:0]] <= mem_wdata_w[0];
        rp0 <= (mem_en_w[0] && !mem_we_w[0]) ? hw_mem0[mem_addr_w[0][7:0]] : 32'hA5A5_A5A5;
        if (mem_en_w[1] && mem_we_w[1]) hw_mem1[mem_addr_w[1][7:0]] <= mem_wdata_w[1];
        rp1[0] <= (mem_en_w[1] && !mem_we_w[1]) ? hw_mem1[mem_addr_w[1][7:0]] : 32'hA5A5_A5A5;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign mem_rdata_w[0] = rp0;
    assign mem_rdata_w[1] = rp1[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: each access is a timeline measured in cycles since its grant.
    int          age[2];
    int          m_streak[2];
    logic        m_own_dm[2], m_we[2];
    logic [31:0] m_addr[2], m_wdata[2], m_data[2], m_if_rd[2], m_dm_rd[2];
    logic [31:0] ref_mem[2][256];

    // Observation logs for the directed checks (first-event cycles, last data).
    int          n_ifg[2], n_dmg[2], n_en[2], n_ifrv[2], n_dmrv[2];
    int          c_ifg[2], c_en[2], c_ifrv[2], c_dmrv[2];
    logic [31:0] a_en[2], d_ifrv[2], d_dmrv[2];
    string       gseq;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_s(input string tag, input string obs, input string exp);
        tests++;
        assert (obs == exp) else begin
            fails++;
            $error("FAIL %s observed=%s expected=%s", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        for (int k = 0; k < 2; k++) begin
            n_ifg[k] = 0; n_dmg[k] = 0; n_en[k] = 0; n_ifrv[k] = 0; n_dmrv[k] = 0;
            c_ifg[k] = -100; c_en[k] = -100; c_ifrv[k] = -100; c_dmrv[k] = -100;
            a_en[k] = '0; d_ifrv[k] = '0; d_dmrv[k] = '0;
        end
        gseq = "";
    endtask

    task automatic model_check(input int k);
        int   lat;
        logic e_ifg, e_dmg, resp;
        logic [7:0] idx;
        string p;
        lat = (k == 0) ? 1 : 3;
        p   = $sformatf("L%0d_", lat);
        if (reset) begin
            age[k] = -1; m_streak[k] = 0; m_own_dm[k] = 1'b0; m_we[k] = 1'b0;
            m_addr[k] = '0; m_wdata[k] = '0; m_if_rd[k] = '0; m_dm_rd[k] = '0;
        end
        e_dmg = !reset && (age[k] < 0) && dm_req && !(if_req && m_streak[k] == MAXS);
        e_ifg = !reset && (age[k] < 0) && if_req && !e_dmg;
        resp  = !reset && (age[k] == lat + 2);
        if (resp) begin
            if (m_own_dm[k]) m_dm_rd[k] = m_data[k];
            else             m_if_rd[k] = m_data[k];
        end
        chk_b({p, "if_gnt"},    if_gnt_w[k],    e_ifg);
        chk_b({p, "dm_gnt"},    dm_gnt_w[k],    e_dmg);
        chk_b({p, "mem_en"},    mem_en_w[k],    age[k] == 1);
        chk_b({p, "mem_we"},    mem_we_w[k],    (age[k] == 1) && m_we[k]);
        chk_w({p, "mem_addr"},  mem_addr_w[k],  m_addr[k]);
        chk_w({p, "mem_wdata"}, mem_wdata_w[k], m_wdata[k]);
        chk_b({p, "if_rvalid"}, if_rvalid_w[k], resp && !m_own_dm[k]);
        chk_b({p, "dm_rvalid"}, dm_rvalid_w[k], resp && m_own_dm[k]);
        chk_w({p, "if_rdata"},  if_rdata_w[k],  m_if_rd[k]);
        chk_w({p, "dm_rdata"},  dm_rdata_w[k],  m_dm_rd[k]);

        if (if_gnt_w[k]) begin
            if (n_ifg[k] == 0) c_ifg[k] = cyc;
            n_ifg[k]++;
            if (k == 0) gseq = {gseq, "I"};
        end
        if (dm_gnt_w[k]) begin
            n_dmg[k]++;
            if (k == 0) gseq = {gseq, "D"};
        end
        if (mem_en_w[k]) begin
            if (n_en[k] == 0) begin c_en[k] = cyc; a_en[k] = mem_addr_w[k]; end
            n_en[k]++;
        end
        if (if_rvalid_w[k]) begin
            if (n_ifrv[k] == 0) c_ifrv[k] = cyc;
            n_ifrv[k]++;
            d_ifrv[k] = if_rdata_w[k];
        end
        if (dm_rvalid_w[k]) begin
            if (n_dmrv[k] == 0) c_dmrv[k] = cyc;
            n_dmrv[k]++;
            d_dmrv[k] = dm_rdata_w[k];
        end

        if (!reset) begin
            if (resp)             age[k] = -1;
            else if (age[k] >= 1) age[k]++;
            if (e_dmg || e_ifg) begin
                age[k]      = 1;
                m_own_dm[k] = e_dmg;
                m_we[k]     = e_dmg && dm_we;
                m_addr[k]   = e_dmg ? dm_addr : if_addr;
                if (e_dmg) m_wdata[k] = dm_wdata;
                idx = m_addr[k][7:0];
                if (m_we[k]) begin
                    ref_mem[k][idx] = m_wdata[k];
                    m_data[k] = '0;
                end else begin
                    m_data[k] = ref_mem[k][idx];
                end
                if (e_dmg && if_req) m_streak[k] = (m_streak[k] < MAXS) ? m_streak[k] + 1 : MAXS;
                else                 m_streak[k] = 0;
            end
        end
    endtask

    // Called just after a falling edge with this cycle's inputs applied; returns at the next one.
    task automatic tick();
        #1;
        model_check(0);
        model_check(1);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        bit ok;
        for (int i = 0; i < 256; i++) begin
            w = (i == 16) ? 32'h0000_1234 : (32'hC0DE_0000 | (i * 7));
            hw_mem0[i] = w; hw_mem1[i] = w; ref_mem[0][i] = w; ref_mem[1][i] = w;
        end
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        clear_logs();
        @(negedge clk);

        // 1: reset holds outputs at 0, then a single IF read of 0x10.
        if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h10;
        repeat (3) tick();
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        tick();
        clear_logs();
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        if_req = 1'b0;
        repeat (6) tick();
        chk_w("t1_en_lat",   c_en[0] - c_ifg[0], 1);
        chk_w("t1_en_addr",  a_en[0], 32'h10);
        chk_w("t1_rv_lat",   c_ifrv[0] - c_ifg[0], 3);
        chk_w("t1_rdata",    d_ifrv[0], 32'h1234);
        chk_w("t1_rv_count", n_ifrv[0], 1);

        // 2: simultaneous requests -> DM first, IF on the first IDLE after dm_rvalid.
        clear_logs();
        if_req = 1'b1; if_addr = 32'h44; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h08;
        tick();
        dm_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = (n_ifg[0] > 0) && (n_ifg[1] > 0);
        end
        chk_b("t2_if_gnt_seen", ok, 1'b1);
        if_req = 1'b0;
        repeat (10) tick();
        chk_s("t2_order", gseq.substr(0, 1), "DI");
        chk_w("t2_if_after_dm", c_ifg[0] - c_dmrv[0], 1);
        chk_w("t2_if_after_dm_l3", c_ifg[1] - c_dmrv[1], 1);

        // 3: both requests held -> streak bound lets IF in every fifth grant.
        clear_logs();
        if_req = 1'b1; if_addr = 32'h50; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h60;
        repeat (50) tick();
        if_req = 1'b0; dm_req = 1'b0;
        repeat (10) tick();
        chk_s("t3_order", gseq.substr(0, 9), "DDDDIDDDDI");

        // 4: DM write then read back.
        clear_logs();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
        tick();
        dm_req = 1'b0;
        repeat (8) tick();
        chk_w("t4_wr_rv_count", n_dmrv[0], 1);
        chk_w("t4_wr_rdata",    d_dmrv[0], 32'h0);
        clear_logs();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        tick();
        dm_req = 1'b0;
        repeat (8) tick();
        chk_w("t4_rd_rdata",    d_dmrv[0], 32'hDEAD_BEEF);
        chk_w("t4_rd_rdata_l3", d_dmrv[1], 32'hDEAD_BEEF);

        // 5: reset while the MEM_LAT=3 instance is in WAIT; nothing completes afterwards.
        clear_logs();
        if_req = 1'b1; if_addr = 32'h30;
        tick();
        if_req = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        clear_logs();
        repeat (10) tick();
        chk_w("t5_no_rv_l3", n_ifrv[1], 0);
        chk_w("t5_no_rv_l1", n_ifrv[0], 0);
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        if_req = 1'b0;
        repeat (8) tick();
        chk_w("t5_after_rv_l3",  n_ifrv[1], 1);
        chk_w("t5_after_lat_l3", c_ifrv[1] - c_ifg[1], 5);
        chk_w("t5_after_data",   d_ifrv[1], 32'h1234);

        // 6: IF request raised in WAIT and dropped before RESP is ignored.
        clear_logs();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        tick();
        dm_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h70;
        tick();
        if_req = 1'b0;
        repeat (8) tick();
        chk_w("t6_no_if_gnt", n_ifg[0], 0);
        chk_w("t6_one_mem_en", n_en[0], 1);
        chk_w("t6_dm_rv", n_dmrv[0], 1);

        // Random traffic with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 800; i++) begin
            if_req   = ($urandom % 4) != 0;
            dm_req   = ($urandom % 3) != 0;
            dm_we    = $urandom % 2;
            if_addr  = $urandom;
            dm_addr  = $urandom;
            dm_wdata = $urandom;
            reset    = ($urandom % 200) == 0;
            tick();
        end
        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
